// File: rtl/timer_16bit_count_control.sv
// Timer1 count engine: derives ticks from the prescaler or the T1 pin, computes the next TCNT1,
// and raises registered compare/overflow flag pulses plus level interrupt requests.
module timer_16bit_count_control #(
  parameter int PRESCALE_WIDTH = 10,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        i_sys_clock,
  input  logic        i_system_reset,
  input  logic [7:0]  i_tccr,
  input  logic [15:0] i_tcnt,
  input  logic [15:0] i_ocr,
  input  logic [7:0]  i_timsk,
  input  logic [7:0]  i_tifr,
  input  logic        i_cpu_tcnt_write,
  input  logic        i_t1_pin,
  input  logic        i_irq_ack_cmp,
  input  logic        i_irq_ack_ovf,
  output logic [15:0] o_tcnt_next,
  output logic        o_tcnt_update,
  output logic [7:0]  o_tifr_set,
  output logic [7:0]  o_tifr_clear,
  output logic        o_cmp_irq,
  output logic        o_ovf_irq
);

  typedef enum logic [2:0] {
    CS_STOP    = 3'b000,
    CS_DIV1    = 3'b001,
    CS_DIV8    = 3'b010,
    CS_DIV64   = 3'b011,
    CS_DIV256  = 3'b100,
    CS_DIV1024 = 3'b101,
    CS_T1_FALL = 3'b110,
    CS_T1_RISE = 3'b111
  } cs_e;

  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

  logic [PRESCALE_WIDTH-1:0] r_prescaler;
  logic [SYNC_STAGES-1:0]    r_t1_sync;
  logic                      r_t1_hist;
  logic [PRIME_W-1:0]        r_prime;
  logic [7:0]                r_tifr_set;
  logic [7:0]                r_tifr_clear;

  logic w_t1_sync_out;
  logic w_primed;
  logic w_t1_rise;
  logic w_t1_fall;
  logic w_tick;
  logic w_step;
  logic w_compare;
  logic w_set_cmp;
  logic w_set_ovf;
  logic w_unused_bits;

  assign w_t1_sync_out = r_t1_sync[SYNC_STAGES-1];
  // Edge history is meaningless until the chain has refilled after reset; a pin held high
  // through reset must not look like a rising edge.
  assign w_primed      = (r_prime == PRIME_W'(PRIME_MAX));
  assign w_t1_rise     = w_primed &  w_t1_sync_out & ~r_t1_hist;
  assign w_t1_fall     = w_primed & ~w_t1_sync_out &  r_t1_hist;

  always_comb begin
    // NOTE: default first so every path assigns w_tick and no latch is inferred.
    w_tick = 1'b0;
    case (cs_e'(i_tccr[2:0]))
      CS_STOP:    w_tick = 1'b0;
      CS_DIV1:    w_tick = 1'b1;
      CS_DIV8:    w_tick = &r_prescaler[2:0];
      CS_DIV64:   w_tick = &r_prescaler[5:0];
      CS_DIV256:  w_tick = &r_prescaler[7:0];
      CS_DIV1024: w_tick = &r_prescaler[9:0];
      CS_T1_FALL: w_tick = w_t1_fall;
      CS_T1_RISE: w_tick = w_t1_rise;
      default:    w_tick = 1'b0;
    endcase
  end

  // A CPU write to TCNT1 overrides the count step; no counting while reset is held.
  assign w_step    = w_tick & ~i_cpu_tcnt_write & i_system_reset;
  assign w_compare = (i_tcnt == i_ocr);
  assign w_set_cmp = w_step & w_compare;
  assign w_set_ovf = w_step & (i_tcnt == 16'hFFFF);

  always_comb begin
    o_tcnt_update = w_step;
    o_tcnt_next   = i_tcnt;
    if (w_step) begin
      o_tcnt_next = (i_tccr[3] && w_compare) ? 16'h0000 : i_tcnt + 16'd1;
    end
  end

  always_ff @(posedge i_sys_clock) begin
    // NOTE: synchronous reset sampled on the clock edge; all state uses non-blocking updates.
    if (!i_system_reset) begin
      r_prescaler  <= '0;
      r_t1_sync    <= '0;
      r_t1_hist    <= 1'b0;
      r_prime      <= '0;
      r_tifr_set   <= 8'h00;
      r_tifr_clear <= 8'h00;
    end else begin
      r_prescaler <= r_prescaler + 1'b1;
      r_t1_sync   <= {r_t1_sync[SYNC_STAGES-2:0], i_t1_pin};
      r_t1_hist   <= w_t1_sync_out;
      if (r_prime != PRIME_W'(PRIME_MAX)) begin
        r_prime <= r_prime + 1'b1;
      end
      r_tifr_set   <= {3'b000, w_set_cmp, 1'b0, w_set_ovf, 2'b00};
      // A set in the same cycle as an acknowledge wins; the clear is suppressed.
      r_tifr_clear <= {3'b000, i_irq_ack_cmp & ~w_set_cmp, 1'b0, i_irq_ack_ovf & ~w_set_ovf, 2'b00};
    end
  end

  assign o_tifr_set   = r_tifr_set;
  assign o_tifr_clear = r_tifr_clear;
  assign o_cmp_irq    = i_tifr[4] & i_timsk[4];
  assign o_ovf_irq    = i_tifr[2] & i_timsk[2];

  assign w_unused_bits = ^{i_tccr[7:4], i_timsk[7:5], i_timsk[3], i_timsk[1:0],
                           i_tifr[7:5], i_tifr[3], i_tifr[1:0]};

endmodule

// File: tb/tb_timer_16bit_count_control.sv
// Scoreboard bench for timer_16bit_count_control: the driver acts as the TCNT1 register bank,
// predicts each cycle's outputs from the timer rules, and a negedge monitor compares them.
module tb_timer_16bit_count_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tccr, timsk, tifr;
  logic [15:0] tcnt, ocr;
  logic        cpu_wr, t1_pin, ack_cmp, ack_ovf;
  logic [15:0] tcnt_next;
  logic        tcnt_update, cmp_irq, ovf_irq;
  logic [7:0]  tifr_set, tifr_clear;

  always #5 clk = ~clk;

  timer_16bit_count_control #(.PRESCALE_WIDTH(10), .SYNC_STAGES(2)) dut (
    .i_sys_clock     (clk),
    .i_system_reset  (rst_n),
    .i_tccr          (tccr),
    .i_tcnt          (tcnt),
    .i_ocr           (ocr),
    .i_timsk         (timsk),
    .i_tifr          (tifr),
    .i_cpu_tcnt_write(cpu_wr),
    .i_t1_pin        (t1_pin),
    .i_irq_ack_cmp   (ack_cmp),
    .i_irq_ack_ovf   (ack_ovf),
    .o_tcnt_next     (tcnt_next),
    .o_tcnt_update   (tcnt_update),
    .o_tifr_set      (tifr_set),
    .o_tifr_clear    (tifr_clear),
    .o_cmp_irq       (cmp_irq),
    .o_ovf_irq       (ovf_irq)
  );

  typedef struct packed {
    logic        upd;
    logic [15:0] nxt;
    logic [7:0]  set;
    logic [7:0]  clr;
    logic        cirq;
    logic        oirq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Stimulus knobs and model state
  logic        s_rst, s_ctc, s_wr, s_pin, s_ack_cmp, s_ack_ovf;
  logic [2:0]  s_cs;
  logic [15:0] s_ocr, s_wr_val;
  logic [7:0]  s_timsk, s_tifr;
  logic [15:0] bank;
  logic [7:0]  m_set, m_clr;
  bit          pin_at[0:16383];
  int          cyc = 0;
  int          rst_rel = 0;
  bit          push_en = 1'b0;

  task automatic run_cycle();
    exp_t        e;
    bit          tick, step, edge_ok;
    logic [15:0] nxt;
    tccr = {4'h0, s_ctc, s_cs};
    tcnt = bank; ocr = s_ocr; timsk = s_timsk; tifr = s_tifr;
    cpu_wr = s_wr; t1_pin = s_pin; ack_cmp = s_ack_cmp; ack_ovf = s_ack_ovf; rst_n = s_rst;
    pin_at[cyc] = s_pin;

    // The pin value seen by edge detection is the one driven two cycles ago, compared with
    // the one three cycles ago, and only once three full cycles have passed since reset.
    edge_ok = (rst_rel >= 3);
    tick = 1'b0;
    case (s_cs)
      3'd1: tick = 1'b1;
      3'd2: tick = ((rst_rel + 1) % 8) == 0;
      3'd3: tick = ((rst_rel + 1) % 64) == 0;
      3'd4: tick = ((rst_rel + 1) % 256) == 0;
      3'd5: tick = ((rst_rel + 1) % 1024) == 0;
      3'd6: if (edge_ok) tick = !pin_at[cyc-2] && pin_at[cyc-3];
      3'd7: if (edge_ok) tick = pin_at[cyc-2] && !pin_at[cyc-3];
      default: tick = 1'b0;
    endcase
    step = s_rst && tick && !s_wr;
    nxt  = bank;
    if (step) nxt = (s_ctc && bank == s_ocr) ? 16'h0000 : bank + 16'd1;

    e.upd = step; e.nxt = nxt; e.set = m_set; e.clr = m_clr;
    e.cirq = s_tifr[4] & s_timsk[4];
    e.oirq = s_tifr[2] & s_timsk[2];
    if (push_en) exp_q.push_back(e);

    if (!s_rst) begin
      m_set = 8'h00; m_clr = 8'h00;
    end else begin
      m_set = 8'h00; m_clr = 8'h00;
      m_set[4] = step && (bank == s_ocr);
      m_set[2] = step && (bank == 16'hFFFF);
      m_clr[4] = s_ack_cmp && !m_set[4];
      m_clr[2] = s_ack_ovf && !m_set[2];
    end

    if (!s_rst)     bank = 16'h0000;
    else if (s_wr)  bank = s_wr_val;
    else if (step)  bank = nxt;

    rst_rel = s_rst ? rst_rel + 1 : 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic write_tcnt(input logic [15:0] v);
    s_wr = 1'b1; s_wr_val = v;
    run_cycle();
    s_wr = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tcnt_update", 32'(tcnt_update), 32'(e.upd));
      check("tcnt_next",   32'(tcnt_next),   32'(e.nxt));
      check("tifr_set",    32'(tifr_set),    32'(e.set));
      check("tifr_clear",  32'(tifr_clear),  32'(e.clr));
      check("cmp_irq",     32'(cmp_irq),     32'(e.cirq));
      check("ovf_irq",     32'(ovf_irq),     32'(e.oirq));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_rst = 1'b0; s_cs = 3'd1; s_ctc = 1'b0; s_ocr = 16'hFFFF; s_timsk = 8'h00; s_tifr = 8'h00;
    s_wr = 1'b0; s_wr_val = 16'h0000; s_pin = 1'b1; s_ack_cmp = 1'b0; s_ack_ovf = 1'b0;
    bank = 16'h0000; m_set = 8'h00; m_clr = 8'h00;
    @(posedge clk); #1;

    // Reset with the T1 pin held high, then count on rising edges: no step may appear.
    run_cycle();
    push_en = 1'b1;
    s_ack_cmp = 1'b1; s_ack_ovf = 1'b1;
    repeat (2) run_cycle();
    s_ack_cmp = 1'b0; s_ack_ovf = 1'b0;
    s_rst = 1'b1; s_cs = 3'd7;
    repeat (8) run_cycle();

    // Normal-mode wrap through FFFF.
    s_cs = 3'd1;
    write_tcnt(16'hFFFE);
    repeat (4) run_cycle();

    // clk/64 over 640 cycles, then stopped.
    s_cs = 3'd3;
    write_tcnt(16'h0000);
    repeat (640) run_cycle();
    s_cs = 3'd0;
    repeat (20) run_cycle();

    // CTC on OCR1A = 5.
    s_cs = 3'd1; s_ctc = 1'b1; s_ocr = 16'h0005;
    write_tcnt(16'h0000);
    repeat (100) run_cycle();

    // External clock, rising then falling edges, pin toggling every 10 cycles.
    s_ctc = 1'b0; s_ocr = 16'hFFFF; s_cs = 3'd7;
    for (int i = 0; i < 100; i++) begin
      s_pin = ((i / 10) % 2) == 0;
      run_cycle();
    end
    s_cs = 3'd6;
    for (int i = 0; i < 100; i++) begin
      s_pin = ((i / 10) % 2) == 1;
      run_cycle();
    end

    // CPU write coinciding with a tick at compare: step and flag dropped.
    s_cs = 3'd1; s_ocr = 16'h0021;
    write_tcnt(16'h0020);
    run_cycle();
    write_tcnt(16'h0100);
    repeat (2) run_cycle();

    // Interrupt levels and acknowledge colliding with overflow.
    s_timsk = 8'h14; s_tifr = 8'h14; s_ocr = 16'h1234;
    write_tcnt(16'hFFFF);
    s_ack_ovf = 1'b1; s_ack_cmp = 1'b1;
    run_cycle();
    s_ack_ovf = 1'b0; s_ack_cmp = 1'b0;
    repeat (3) run_cycle();

    // Randomised mix, including resets mid-count and clock-select changes.
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) s_cs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) s_ctc = ~s_ctc;
      if ($urandom_range(0, 9) == 0) s_ocr = 16'(bank + 16'($urandom_range(0, 4)));
      s_wr = ($urandom_range(0, 29) == 0);
      s_wr_val = ($urandom_range(0, 1) == 0) ? 16'hFFFD : 16'($urandom());
      if ($urandom_range(0, 3) == 0) s_pin = ~s_pin;
      s_ack_cmp = ($urandom_range(0, 7) == 0);
      s_ack_ovf = ($urandom_range(0, 7) == 0);
      s_timsk = 8'($urandom());
      s_tifr  = 8'($urandom());
      run_cycle();
    end
    s_wr = 1'b0; s_rst = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
